// File: rtl/demux_tdm_rx.sv
// Purpose: receive side of the 2:1 TDM link; realigns on slot-0 sync and rebuilds lane pairs.
// Latency: the frame is visible on d/out_valid from the edge that accepts its slot-1 sample.
// Backpressure: in_valid=0 stalls and freezes all state; there is no output-side backpressure.
module demux_tdm_rx #(
    parameter int DW          = 1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_data,
    input  logic            in_sync,
    output logic [0:2*DW-1] d,
    output logic            out_valid,
    output logic            slot,
    output logic            locked,
    output logic            err
);

    // 4 bits covers LOCK_FRAMES up to 15
    localparam int CW = 4;
    localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        EXPECT0 = 2'd1,
        EXPECT1 = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [DW-1:0]     hold0, hold0_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [0:2*DW-1]   d_nx;
    logic              out_valid_nx;
    logic              err_nx;

    // Next-state and next-output decode; non-accepted cycles keep everything except the pulses
    always_comb begin
        state_nx     = state;
        hold0_nx     = hold0;
        cnt_nx       = cnt;
        d_nx         = d;
        out_valid_nx = 1'b0;
        err_nx       = 1'b0;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    // Everything up to the first sync marker is dropped silently
                    if (in_sync) begin
                        hold0_nx = in_data;
                        state_nx = EXPECT1;
                    end
                end
                EXPECT1: begin
                    if (!in_sync) begin
                        // Both slots present: publish the pair as one word
                        d_nx         = {hold0, in_data};
                        out_valid_nx = 1'b1;
                        if (cnt != LOCK_MAX) begin
                            cnt_nx = cnt + 1'b1;
                        end
                        state_nx = EXPECT0;
                    end else begin
                        // Second sync before slot 1: the new sample restarts the frame
                        err_nx   = 1'b1;
                        cnt_nx   = '0;
                        hold0_nx = in_data;
                        state_nx = EXPECT1;
                    end
                end
                EXPECT0: begin
                    if (in_sync) begin
                        hold0_nx = in_data;
                        state_nx = EXPECT1;
                    end else begin
                        // Sync missing where slot 0 belongs: alignment lost, rehunt
                        err_nx   = 1'b1;
                        cnt_nx   = '0;
                        state_nx = HUNT;
                    end
                end
                default: begin
                    state_nx = HUNT;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // State and output registers; reset wins over any accepted sample
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HUNT;
            hold0     <= '0;
            cnt       <= '0;
            d         <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            hold0     <= hold0_nx;
            cnt       <= cnt_nx;
            d         <= d_nx;
            out_valid <= out_valid_nx;
            err       <= err_nx;
        end
    end

    assign locked = (cnt == LOCK_MAX);
    assign slot   = (state == EXPECT1);

endmodule

// File: tb/tb_demux_tdm_rx.sv
// Purpose: self-checking bench for demux_tdm_rx with DW=1, LOCK_FRAMES=2.
// Latency: outputs are checked 1 time unit after each rising edge.
// Backpressure: stall cycles are driven explicitly with in_valid=0.
module tb_demux_tdm_rx;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [0:0]  in_data;
    logic        in_sync;
    logic [0:1]  d;
    logic        out_valid;
    logic        slot;
    logic        locked;
    logic        err;

    int errors;
    int checks;

    logic [0:1] sb_q[$];

    typedef struct {
        logic       rst_n;
        logic       vld;
        logic       sync;
        logic       dat;
        logic       ov;
        logic       er;
        logic       sl;
        logic       lk;
        logic [0:1] dexp;
    } vec_t;

    vec_t tbl[$];

    demux_tdm_rx #(.DW(1), .LOCK_FRAMES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sync   (in_sync),
        .d         (d),
        .out_valid (out_valid),
        .slot      (slot),
        .locked    (locked),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic v, input logic s, input logic dt,
                                input logic ov, input logic er, input logic sl, input logic lk,
                                input logic [0:1] dx);
        vec_t t;
        t.rst_n = r; t.vld = v; t.sync = s; t.dat = dt;
        t.ov = ov; t.er = er; t.sl = sl; t.lk = lk; t.dexp = dx;
        return t;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk2(input string nm, input logic [0:1] act, input logic [0:1] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Drive one cycle, then compare all outputs and drain the scoreboard on out_valid
    task automatic apply(input string tag, input vec_t v);
        logic [0:1] sb_exp;
        rst_n    = v.rst_n;
        in_valid = v.vld;
        in_sync  = v.sync;
        in_data  = v.dat;
        if (v.ov) sb_q.push_back(v.dexp);
        @(posedge clk);
        #1;
        chk1({tag, " out_valid"}, out_valid, v.ov);
        chk1({tag, " err"},       err,       v.er);
        chk1({tag, " slot"},      slot,      v.sl);
        chk1({tag, " locked"},    locked,    v.lk);
        chk2({tag, " d"},         d,         v.dexp);
        if (out_valid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL %s scoreboard: out_valid with d=%b but no frame expected", tag, d);
            end else begin
                sb_exp = sb_q.pop_front();
                if (d !== sb_exp) begin
                    errors++;
                    $display("FAIL %s scoreboard: frame d=%b expected %b", tag, d, sb_exp);
                end
            end
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sync  = 1'b0;
        in_data  = 1'b0;

        //            rst v  s  dat   ov er sl lk  d
        // reset state
        tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0, 2'b00));
        tbl.push_back(mk(0, 1, 1, 1,   0, 0, 0, 0, 2'b00));
        // basic stream: frames 01 then 10, lock on the second
        tbl.push_back(mk(1, 1, 1, 0,   0, 0, 1, 0, 2'b00));
        tbl.push_back(mk(1, 1, 0, 1,   1, 0, 0, 0, 2'b01));
        tbl.push_back(mk(1, 1, 1, 1,   0, 0, 1, 0, 2'b01));
        tbl.push_back(mk(1, 1, 0, 0,   1, 0, 0, 1, 2'b10));
        // start mid-frame: leading non-sync samples dropped without err
        tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0, 2'b00));
        tbl.push_back(mk(1, 1, 0, 1,   0, 0, 0, 0, 2'b00));
        tbl.push_back(mk(1, 1, 0, 1,   0, 0, 0, 0, 2'b00));
        tbl.push_back(mk(1, 1, 1, 1,   0, 0, 1, 0, 2'b00));
        tbl.push_back(mk(1, 1, 0, 1,   1, 0, 0, 0, 2'b11));
        // double sync: err, second sample becomes slot 0
        tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0, 2'b00));
        tbl.push_back(mk(1, 1, 1, 1,   0, 0, 1, 0, 2'b00));
        tbl.push_back(mk(1, 1, 1, 0,   0, 1, 1, 0, 2'b00));
        tbl.push_back(mk(1, 1, 0, 1,   1, 0, 0, 0, 2'b01));
        // missing sync after three good frames (counter saturated)
        tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0, 2'b00));
        tbl.push_back(mk(1, 1, 1, 1,   0, 0, 1, 0, 2'b00));
        tbl.push_back(mk(1, 1, 0, 0,   1, 0, 0, 0, 2'b10));
        tbl.push_back(mk(1, 1, 1, 0,   0, 0, 1, 0, 2'b10));
        tbl.push_back(mk(1, 1, 0, 1,   1, 0, 0, 1, 2'b01));
        tbl.push_back(mk(1, 1, 1, 1,   0, 0, 1, 1, 2'b01));
        tbl.push_back(mk(1, 1, 0, 1,   1, 0, 0, 1, 2'b11));
        tbl.push_back(mk(1, 1, 0, 1,   0, 1, 0, 0, 2'b11));
        tbl.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0, 2'b11));
        tbl.push_back(mk(1, 1, 1, 0,   0, 0, 1, 0, 2'b11));
        tbl.push_back(mk(1, 1, 0, 0,   1, 0, 0, 0, 2'b00));

        for (int i = 0; i < tbl.size(); i++) begin
            apply($sformatf("vec%0d", i), tbl[i]);
        end

        // Stalls between slots: d, slot and locked frozen until slot 1 arrives
        apply("st_rst", mk(0, 0, 0, 0,   0, 0, 0, 0, 2'b00));
        apply("st_a0",  mk(1, 1, 1, 1,   0, 0, 1, 0, 2'b00));
        apply("st_a1",  mk(1, 1, 0, 1,   1, 0, 0, 0, 2'b11));
        apply("st_b0",  mk(1, 1, 1, 1,   0, 0, 1, 0, 2'b11));
        for (int i = 0; i < 3; i++) begin
            apply($sformatf("st_b_stall%0d", i), mk(1, 0, 0, 0, 0, 0, 1, 0, 2'b11));
        end
        apply("st_b1",  mk(1, 1, 0, 0,   1, 0, 0, 1, 2'b10));
        apply("st_c0",  mk(1, 1, 1, 0,   0, 0, 1, 1, 2'b10));
        for (int i = 0; i < 2; i++) begin
            apply($sformatf("st_c_stall%0d", i), mk(1, 0, 1, 1, 0, 0, 1, 1, 2'b10));
        end
        apply("st_c1",  mk(1, 1, 0, 1,   1, 0, 0, 1, 2'b01));

        // Reset between slot 0 and slot 1, with in_valid high to show reset priority
        apply("mr_a0",  mk(1, 1, 1, 1,   0, 0, 1, 1, 2'b01));
        apply("mr_rst", mk(0, 1, 1, 1,   0, 0, 0, 0, 2'b00));
        apply("mr_a1",  mk(1, 1, 0, 1,   0, 0, 0, 0, 2'b00));
        apply("mr_idle", mk(1, 0, 0, 0,  0, 0, 0, 0, 2'b00));

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d frames never seen, expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
